// File: rtl/ddr3_req_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller CPU port among NUM_REQ requesters.
// Tracks each transaction until the controller is ready again and watches for hangs.
module ddr3_req_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 29,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                        i_cpu_ck,
    input  logic                        i_cpu_reset_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_wr_data,
    output logic [NUM_REQ-1:0]          o_req_ack,
    output logic [NUM_REQ-1:0]          o_req_done,
    output logic [NUM_REQ-1:0]          o_req_rd_valid,
    output logic [DATA_W-1:0]           o_req_rd_data,
    output logic                        o_ctrl_valid,
    output logic                        o_ctrl_cmd,
    output logic [ADDR_W-1:0]           o_ctrl_addr,
    output logic [DATA_W-1:0]           o_ctrl_wr_data,
    input  logic                        i_ctrl_rdy,
    input  logic                        i_ctrl_rd_valid,
    input  logic [DATA_W-1:0]           i_ctrl_rd_data,
    output logic                        o_timeout_err
);

    localparam int unsigned OWN_W = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = $clog2(2 * NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [OWN_W-1:0]   ptr;
    logic [OWN_W-1:0]   owner;
    logic [WD_W-1:0]    wd;

    logic               grant_found;
    logic [OWN_W-1:0]   grant_idx;
    logic [OWN_W-1:0]   next_ptr;
    logic [SUM_W-1:0]   cand;

    // First pending request at or above the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = SUM_W'(ptr) + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!grant_found && i_req_valid[OWN_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = OWN_W'(cand);
            end
        end
    end

    assign next_ptr = (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0 : grant_idx + OWN_W'(1);

    always_ff @(posedge i_cpu_ck) begin
        if (!i_cpu_reset_n) begin
            state          <= ST_ARB;
            ptr            <= '0;
            owner          <= '0;
            wd             <= '0;
            o_req_ack      <= '0;
            o_req_done     <= '0;
            o_req_rd_valid <= '0;
            o_req_rd_data  <= '0;
            o_ctrl_valid   <= 1'b0;
            o_ctrl_cmd     <= 1'b0;
            o_ctrl_addr    <= '0;
            o_ctrl_wr_data <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            o_req_ack      <= '0;
            o_req_done     <= '0;
            o_req_rd_valid <= '0;
            o_ctrl_valid   <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (i_ctrl_rdy && grant_found) begin
                        owner          <= grant_idx;
                        ptr            <= next_ptr;
                        o_ctrl_cmd     <= i_req_cmd[grant_idx];
                        o_ctrl_addr    <= i_req_addr[grant_idx*ADDR_W +: ADDR_W];
                        o_ctrl_wr_data <= i_req_wr_data[grant_idx*DATA_W +: DATA_W];
                        o_ctrl_valid   <= 1'b1;
                        o_req_ack      <= NUM_REQ'(1) << grant_idx;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd    <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data is only meaningful for the read currently in flight.
                    if (i_ctrl_rd_valid && !o_ctrl_cmd) begin
                        o_req_rd_data  <= i_ctrl_rd_data;
                        o_req_rd_valid <= NUM_REQ'(1) << owner;
                    end
                    if (i_ctrl_rdy) begin
                        o_req_done <= NUM_REQ'(1) << owner;
                        wd         <= '0;
                        state      <= ST_ARB;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        o_timeout_err <= 1'b1;
                        o_req_done    <= NUM_REQ'(1) << owner;
                        wd            <= '0;
                        state         <= ST_ARB;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Bench for ddr3_req_arbiter: controller model, event scoreboard, vector table
// and hand-written sequences for arbitration order, timeout and reset abort.
module tb_ddr3_req_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 64;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_cmd;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wr_data;
    logic [NR-1:0]        o_req_ack;
    logic [NR-1:0]        o_req_done;
    logic [NR-1:0]        o_req_rd_valid;
    logic [DW-1:0]        o_req_rd_data;
    logic                 o_ctrl_valid;
    logic                 o_ctrl_cmd;
    logic [AW-1:0]        o_ctrl_addr;
    logic [DW-1:0]        o_ctrl_wr_data;
    logic                 ctrl_rdy;
    logic                 ctrl_rd_valid;
    logic [DW-1:0]        ctrl_rd_data;
    logic                 o_timeout_err;

    ddr3_req_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .i_cpu_ck       (clk),
        .i_cpu_reset_n  (rst_n),
        .i_req_valid    (req_valid),
        .i_req_cmd      (req_cmd),
        .i_req_addr     (req_addr),
        .i_req_wr_data  (req_wr_data),
        .o_req_ack      (o_req_ack),
        .o_req_done     (o_req_done),
        .o_req_rd_valid (o_req_rd_valid),
        .o_req_rd_data  (o_req_rd_data),
        .o_ctrl_valid   (o_ctrl_valid),
        .o_ctrl_cmd     (o_ctrl_cmd),
        .o_ctrl_addr    (o_ctrl_addr),
        .o_ctrl_wr_data (o_ctrl_wr_data),
        .i_ctrl_rdy     (ctrl_rdy),
        .i_ctrl_rd_valid(ctrl_rd_valid),
        .i_ctrl_rd_data (ctrl_rd_data),
        .o_timeout_err  (o_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int            kind;   // 0 ack, 1 read data, 2 done
        logic [NR-1:0] mask;
        logic [AW-1:0] addr;
        logic          cmd;
        logic [DW-1:0] data;
        bit            lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            idx;
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            busy;
        logic [NR-1:0] exp_mask;
        bit            exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input logic [NR-1:0] m, input logic [AW-1:0] a, input logic c,
                            input logic [DW-1:0] d);
        sb.push_back('{kind: 0, mask: m, addr: a, cmd: c, data: d, lat: 1'b0});
    endtask

    task automatic push_rd(input logic [NR-1:0] m, input logic [DW-1:0] d);
        sb.push_back('{kind: 1, mask: m, addr: '0, cmd: 1'b0, data: d, lat: 1'b1});
    endtask

    task automatic push_done(input logic [NR-1:0] m, input bit lat);
        sb.push_back('{kind: 2, mask: m, addr: '0, cmd: 1'b0, data: '0, lat: lat});
    endtask

    // Controller model: drops rdy after a valid, pulses read data, then returns to ready.
    bit            m_busy = 1'b0;
    int            m_cnt = 0;
    int            ctl_busy = 3;
    bit            ctl_hang = 1'b0;
    bit            rdy_force_low = 1'b0;
    logic [DW-1:0] ctl_rdata = '0;
    int            last_rdv_cyc = -10;
    int            last_rdy_cyc = -10;

    initial begin
        ctrl_rdy      = 1'b1;
        ctrl_rd_valid = 1'b0;
        ctrl_rd_data  = '0;
        forever begin
            @(posedge clk); #1;
            ctrl_rd_valid = 1'b0;
            if (!m_busy) begin
                ctrl_rdy = !rdy_force_low;
                if (o_ctrl_valid === 1'b1) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                ctrl_rdy = 1'b0;
                m_cnt++;
                if (!ctl_hang && m_cnt == ctl_busy) begin
                    ctrl_rd_valid = 1'b1;
                    ctrl_rd_data  = ctl_rdata;
                    last_rdv_cyc  = cyc;
                end else if (!ctl_hang && m_cnt > ctl_busy) begin
                    ctrl_rdy     = 1'b1;
                    m_busy       = 1'b0;
                    last_rdy_cyc = cyc;
                end
            end
        end
    end

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        e = '{kind: -1, mask: '0, addr: '0, cmd: 1'b0, data: '0, lat: 1'b0};
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
            ok = 1'b0;
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
            chk("event_kind", 64'(kind), 64'(e.kind));
        end
    endtask

    // Output monitor: every pulse must match the next expected event.
    initial begin : monitor
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (o_ctrl_valid || (o_req_ack != '0)) begin
                chk("ctrl_valid_with_ack", 64'({o_ctrl_valid, o_req_ack != '0}), 64'(2'b11));
                pop_exp(0, e, ok);
                if (ok) begin
                    chk("ack_mask", 64'(o_req_ack), 64'(e.mask));
                    chk("ctrl_addr", 64'(o_ctrl_addr), 64'(e.addr));
                    chk("ctrl_cmd", 64'(o_ctrl_cmd), 64'(e.cmd));
                    chk("ctrl_wr_data", o_ctrl_wr_data, e.data);
                end
            end
            if (o_req_rd_valid != '0) begin
                pop_exp(1, e, ok);
                if (ok) begin
                    chk("rd_mask", 64'(o_req_rd_valid), 64'(e.mask));
                    chk("rd_data", o_req_rd_data, e.data);
                    chk("rd_latency", 64'(cyc), 64'(last_rdv_cyc + 1));
                end
            end
            if (o_req_done != '0) begin
                pop_exp(2, e, ok);
                if (ok) begin
                    chk("done_mask", 64'(o_req_done), 64'(e.mask));
                    if (e.lat) chk("done_latency", 64'(cyc), 64'(last_rdy_cyc + 1));
                end
            end
        end
    end

    task automatic wait_pulse(input bit is_done, input string name);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            seen = is_done ? (o_req_done != '0) : (o_req_ack != '0);
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no pulse within 400 cycles, expected one", name);
        end
    endtask

    task automatic drive_req(input int idx, input logic c, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        req_cmd[idx]             = c;
        req_addr[idx*AW +: AW]   = a;
        req_wr_data[idx*DW +: DW] = d;
        req_valid[idx]           = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"}, 64'(o_req_ack), 64'd0);
        chk({tag, "_done"}, 64'(o_req_done), 64'd0);
        chk({tag, "_rd_valid"}, 64'(o_req_rd_valid), 64'd0);
        chk({tag, "_rd_data"}, o_req_rd_data, 64'd0);
        chk({tag, "_ctrl_valid"}, 64'(o_ctrl_valid), 64'd0);
        chk({tag, "_ctrl_cmd"}, 64'(o_ctrl_cmd), 64'd0);
        chk({tag, "_ctrl_addr"}, 64'(o_ctrl_addr), 64'd0);
        chk({tag, "_ctrl_wr_data"}, o_ctrl_wr_data, 64'd0);
        chk({tag, "_timeout_err"}, 64'(o_timeout_err), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    vec_t vecs[5];
    int   rr_order[5];

    initial begin
        bit            ok_flag;
        logic [NR-1:0] m;

        vecs[0] = '{idx: 2, cmd: 1'b0, addr: 29'h0001_2340, wdata: 64'h0,
                    rdata: 64'hDEAD_BEEF_0123_4567, busy: 3, exp_mask: 4'b0100, exp_rd: 1'b1};
        vecs[1] = '{idx: 0, cmd: 1'b1, addr: 29'h0000_0ABC, wdata: 64'h1122_3344_5566_7788,
                    rdata: 64'hFFFF_0000_FFFF_0000, busy: 2, exp_mask: 4'b0001, exp_rd: 1'b0};
        vecs[2] = '{idx: 3, cmd: 1'b0, addr: 29'h1FFF_FFFF, wdata: 64'hA5A5_A5A5_A5A5_A5A5,
                    rdata: 64'h0123_4567_89AB_CDEF, busy: 1, exp_mask: 4'b1000, exp_rd: 1'b1};
        vecs[3] = '{idx: 1, cmd: 1'b1, addr: 29'h0, wdata: 64'hFFFF_FFFF_FFFF_FFFF,
                    rdata: 64'h5555_5555_5555_5555, busy: 5, exp_mask: 4'b0010, exp_rd: 1'b0};
        vecs[4] = '{idx: 1, cmd: 1'b0, addr: 29'h0ABC_DEF0, wdata: 64'h0000_0000_0000_0042,
                    rdata: 64'h8000_0000_0000_0001, busy: 4, exp_mask: 4'b0010, exp_rd: 1'b1};
        rr_order = '{0, 1, 2, 3, 0};

        rst_n       = 1'b0;
        req_valid   = '0;
        req_cmd     = '0;
        req_addr    = '0;
        req_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single transactions from the vector table.
        for (int i = 0; i < 5; i++) begin
            ctl_busy  = vecs[i].busy;
            ctl_rdata = vecs[i].rdata;
            push_ack(vecs[i].exp_mask, vecs[i].addr, vecs[i].cmd, vecs[i].wdata);
            if (vecs[i].exp_rd) push_rd(vecs[i].exp_mask, vecs[i].rdata);
            push_done(vecs[i].exp_mask, 1'b1);
            @(posedge clk); #1;
            drive_req(vecs[i].idx, vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            wait_pulse(1'b0, "vec_ack");
            @(posedge clk); #1;
            req_valid[vecs[i].idx] = 1'b0;
            wait_pulse(1'b1, "vec_done");
            repeat (2) @(posedge clk);
        end

        // All requesters at once from pointer 0; requester 0 re-competes after its ack.
        do_reset("rr_reset");
        ctl_busy = 2;
        for (int k = 0; k < 5; k++) begin
            m = NR'(1) << rr_order[k];
            push_ack(m, AW'(32'h100 + rr_order[k]), 1'b1, DW'(64'hC0DE_0000 + rr_order[k]));
            push_done(m, 1'b1);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) drive_req(i, 1'b1, AW'(32'h100 + i), DW'(64'hC0DE_0000 + i));
        for (int k = 0; k < 5; k++) begin
            wait_pulse(1'b0, "rr_ack");
            @(posedge clk); #1;
            if (k != 0) req_valid[rr_order[k]] = 1'b0;
        end
        wait_pulse(1'b1, "rr_done");
        repeat (2) @(posedge clk);

        // Controller busy at ARB: no grant until rdy rises, ack one cycle later.
        @(negedge clk);
        rdy_force_low = 1'b1;
        push_ack(4'b0010, 29'h0BAD_0000, 1'b1, 64'h7777_6666_5555_4444);
        push_done(4'b0010, 1'b1);
        @(posedge clk); #1;
        drive_req(1, 1'b1, 29'h0BAD_0000, 64'h7777_6666_5555_4444);
        ok_flag = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (o_req_ack != '0) ok_flag = 1'b0;
        end
        chk("no_grant_while_not_rdy", 64'(ok_flag), 64'd1);
        rdy_force_low = 1'b0;
        @(negedge clk);
        chk("no_ack_in_rdy_rise_cycle", 64'(o_req_ack), 64'd0);
        @(negedge clk);
        chk("grant_latency_ack", 64'(o_req_ack), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_pulse(1'b1, "busy_done");
        repeat (2) @(posedge clk);

        // Hung controller: error and done after TIMEOUT cycles of WAIT.
        ctl_hang = 1'b1;
        push_ack(4'b1000, 29'h0000_7000, 1'b0, 64'h0);
        push_done(4'b1000, 1'b0);
        @(posedge clk); #1;
        drive_req(3, 1'b0, 29'h0000_7000, 64'h0);
        wait_pulse(1'b0, "to_ack");
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        ok_flag = 1'b1;
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            if (o_timeout_err || (o_req_done != '0)) ok_flag = 1'b0;
        end
        chk("no_early_timeout", 64'(ok_flag), 64'd1);
        @(negedge clk);
        chk("timeout_err_rise", 64'(o_timeout_err), 64'd1);
        chk("timeout_done", 64'(o_req_done), 64'(4'b1000));
        repeat (5) @(negedge clk);
        chk("timeout_err_sticky", 64'(o_timeout_err), 64'd1);
        do_reset("to_reset");
        ctl_hang = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during WAIT of a read aborts it; pointer restarts at 0.
        ctl_busy  = 6;
        ctl_rdata = 64'hABCD_EF01_2345_6789;
        push_ack(4'b0100, 29'h0002_0000, 1'b0, 64'h0);
        @(posedge clk); #1;
        drive_req(2, 1'b0, 29'h0002_0000, 64'h0);
        wait_pulse(1'b0, "abort_ack");
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        ctl_busy = 2;
        push_ack(4'b0001, 29'h0000_0010, 1'b1, 64'h10);
        push_done(4'b0001, 1'b1);
        push_ack(4'b1000, 29'h0000_0013, 1'b1, 64'h13);
        push_done(4'b1000, 1'b1);
        @(posedge clk); #1;
        drive_req(0, 1'b1, 29'h0000_0010, 64'h10);
        drive_req(3, 1'b1, 29'h0000_0013, 64'h13);
        wait_pulse(1'b0, "post_abort_ack0");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_pulse(1'b0, "post_abort_ack3");
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_pulse(1'b1, "post_abort_done");
        repeat (3) @(posedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
